crc32_stream: RTL and testbench

- Parametrised, streaming Ethernet CRC-32 engine for the MAC datapath. Generalises the byte-wide reflect-and-accumulate CRC to DATA_W-bit beats with per-byte keep.
- Two modes: generate FCS (TX) or check received FCS (RX residue compare).
- Valid/ready handshakes on both sides. One frame result is held until it is consumed.
- Sits between the MAC framer/deframer and the byte FIFO.

---
 rtl/eth_crc_pkg.sv | 46 ++++
 rtl/crc32_lane_update.sv | 25 ++
 rtl/crc32_stream.sv | 119 +++++++++++
 tb/tb_crc32_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_crc_pkg.sv
// Shared constants, bit-reversal helpers and the per-byte CRC-32 step
// used by the streaming Ethernet CRC engine.
package eth_crc_pkg;

  localparam logic [31:0] CRC32_POLY         = 32'h04C11DB7;
  localparam logic [31:0] CRC32_POLY_REFL    = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE_REFL = 32'hDEBB20E3;
  localparam logic [31:0] CRC32_RESIDUE_NORM = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } crc_state_t;

  function automatic logic [7:0] reflect_byte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] reflect32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31-i];
    return r;
  endfunction

  // One byte through the shift register: LSB-first with the reflected
  // polynomial, or MSB-first with the normal one.
  function automatic logic [31:0] crc32_step_byte(input logic [31:0] crc,
                                                  input logic [7:0]  b,
                                                  input logic        reflect);
    logic [31:0] c;
    if (reflect) begin
      c = crc ^ {24'h000000, b};
      for (int i = 0; i < 8; i++)
        c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end else begin
      c = crc ^ {b, 24'h000000};
      for (int i = 0; i < 8; i++)
        c = c[31] ? ((c << 1) ^ CRC32_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_lane_update.sv
// Combinational fold of the first keep_cnt bytes of a beat into the CRC,
// lane 0 first, as a chain of byte steps.
module crc32_lane_update
  import eth_crc_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int REFLECT = 1,
  localparam int NB     = DATA_W / 8,
  localparam int KW     = $clog2(NB + 1)
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  input  logic [KW-1:0]     keep_cnt,
  output logic [31:0]       crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(keep_cnt))
        crc_out = crc32_step_byte(crc_out, data[8*i +: 8], REFLECT != 0);
    end
  end

endmodule

// File: rtl/crc32_stream.sv
// Streaming CRC-32 engine: folds DATA_W-bit beats into the accumulator and
// holds one registered per-frame result (CRC, residue check, length).
module crc32_stream
  import eth_crc_pkg::*;
#(
  parameter int          DATA_W  = 8,
  parameter int          LEN_W   = 16,
  parameter int          REFLECT = 1,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                mode,
  output logic [31:0]         out_crc,
  output logic                out_fcs_ok,
  output logic [LEN_W-1:0]    out_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int NB  = DATA_W / 8;
  localparam int KW  = $clog2(NB + 1);
  localparam int LW1 = LEN_W + 1;
  localparam logic [31:0] RESIDUE =
    (REFLECT != 0) ? CRC32_RESIDUE_REFL : CRC32_RESIDUE_NORM;

  crc_state_t       state;
  logic [31:0]      acc;
  logic [LEN_W-1:0] len;
  logic             mode_q;

  logic             accept;
  logic             start;
  logic             mode_eff;
  logic             run;
  logic [KW-1:0]    keep_cnt;
  logic [31:0]      base_crc;
  logic [31:0]      next_crc;
  logic [LEN_W-1:0] base_len;
  logic [LEN_W-1:0] next_len;
  logic [LEN_W:0]   len_sum;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ACC);

  // Any beat accepted outside ACC opens a new frame from INIT, including
  // one accepted in HOLD while the previous result is being consumed.
  assign start    = (state != ACC);
  assign base_crc = start ? INIT : acc;
  assign base_len = start ? '0 : len;
  assign mode_eff = start ? mode : mode_q;

  always_comb begin
    run      = 1'b1;
    keep_cnt = KW'(NB);
    if (in_last) begin
      keep_cnt = '0;
      for (int i = 0; i < NB; i++) begin
        if (run && in_keep[i]) keep_cnt = KW'(i + 1);
        else                   run      = 1'b0;
      end
    end
  end

  crc32_lane_update #(
    .DATA_W  (DATA_W),
    .REFLECT (REFLECT)
  ) u_lane_update (
    .crc_in   (base_crc),
    .data     (in_data),
    .keep_cnt (keep_cnt),
    .crc_out  (next_crc)
  );

  // Length saturates at all-ones instead of wrapping.
  assign len_sum  = {1'b0, base_len} + LW1'(keep_cnt);
  assign next_len = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= INIT;
      len        <= '0;
      mode_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_crc    <= '0;
      out_fcs_ok <= 1'b0;
      out_len    <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state     <= IDLE;
      end
      if (accept) begin
        acc    <= next_crc;
        len    <= next_len;
        mode_q <= mode_eff;
        if (in_last) begin
          state      <= HOLD;
          out_valid  <= 1'b1;
          out_crc    <= next_crc ^ XOR_OUT;
          out_fcs_ok <= mode_eff && (next_crc == RESIDUE);
          out_len    <= next_len;
        end else begin
          state <= ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream.sv
// Scoreboard bench for crc32_stream: byte-wide and 32-bit instances driven
// with directed frames; a monitor per instance pops expected results.
module tb_crc32_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [7:0]  d8;   logic [0:0] k8;  logic v8, l8, m8, ir8, or8, ok8, ov8, busy8;
  logic [31:0] crc8; logic [15:0] len8;
  logic [31:0] d32;  logic [3:0] k32; logic v32, l32, m32, ir32, or32, ok32, ov32, busy32;
  logic [31:0] crc32; logic [15:0] len32;

  crc32_stream #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_data(d8), .in_keep(k8), .in_valid(v8), .in_last(l8),
    .in_ready(ir8), .mode(m8), .out_crc(crc8), .out_fcs_ok(ok8), .out_len(len8),
    .out_valid(ov8), .out_ready(or8), .busy(busy8));

  crc32_stream #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_data(d32), .in_keep(k32), .in_valid(v32), .in_last(l32),
    .in_ready(ir32), .mode(m32), .out_crc(crc32), .out_fcs_ok(ok32), .out_len(len32),
    .out_valid(ov32), .out_ready(or32), .busy(busy32));

  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t e8, e32;
  int n_compared = 0;
  int n_mismatched = 0;

  logic [7:0] str9[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bitwise reference: reflected CRC-32, init and final XOR all-ones.
  function automatic logic [31:0] ref_crc(input logic [7:0] b[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    if (rst && ov8 && or8) begin
      if (q8.size() == 0) begin
        checkOutput("dut8.unexpected_result", 32'd1, 32'd0);
      end else begin
        e8 = q8.pop_front();
        checkOutput("dut8.crc", crc8, e8.crc);
        checkOutput("dut8.fcs_ok", {31'd0, ok8}, {31'd0, e8.ok});
        checkOutput("dut8.len", {16'd0, len8}, {16'd0, e8.len});
      end
    end
  end

  always @(negedge clk) begin
    if (rst && ov32 && or32) begin
      if (q32.size() == 0) begin
        checkOutput("dut32.unexpected_result", 32'd1, 32'd0);
      end else begin
        e32 = q32.pop_front();
        checkOutput("dut32.crc", crc32, e32.crc);
        checkOutput("dut32.fcs_ok", {31'd0, ok32}, {31'd0, e32.ok});
        checkOutput("dut32.len", {16'd0, len32}, {16'd0, e32.len});
      end
    end
  end

  always @(negedge clk) begin
    if (v32 && l32)
      assert (((k32 + 4'd1) & k32) == 4'd0) else $error("[TB] non-contiguous keep %b", k32);
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit wide, input logic [31:0] data, input logic [3:0] keep,
                               input logic last, input logic md);
    int guard = 0;
    if (wide) begin d32 = data; k32 = keep; l32 = last; m32 = md; v32 = 1'b1; end
    else      begin d8 = data[7:0]; k8 = keep[0]; l8 = last; m8 = md; v8 = 1'b1; end
    @(negedge clk);
    while (!(wide ? ir32 : ir8)) begin
      guard++;
      if (guard > 200) begin
        checkOutput("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    if (wide) v32 = 1'b0; else v8 = 1'b0;
  endtask

  task automatic send_bytes8(input logic [7:0] b[$], input logic md, input logic with_last);
    foreach (b[i]) applyStimulus(1'b0, {24'h0, b[i]}, 4'b0001, with_last && (i == b.size() - 1), md);
  endtask

  task automatic send_words32(input logic [7:0] b[$], input logic md);
    logic [31:0] w;
    logic [3:0]  k;
    for (int i = 0; i < b.size(); i += 4) begin
      w = '0;
      k = '0;
      for (int j = 0; j < 4; j++)
        if (i + j < b.size()) begin w[8*j +: 8] = b[i+j]; k[j] = 1'b1; end
      applyStimulus(1'b1, w, k, (i + 4 >= b.size()), md);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pay[$];
    logic [7:0] frm[$];
    logic [31:0] fcs;

    rst = 1'b0;
    d8 = '0; k8 = '0; v8 = 1'b0; l8 = 1'b0; m8 = 1'b0; or8 = 1'b1;
    d32 = '0; k32 = '0; v32 = 1'b0; l32 = 1'b0; m32 = 1'b0; or32 = 1'b1;
    idle_cycles(3);

    checkOutput("reset.out_valid8", {31'd0, ov8}, 32'd0);
    checkOutput("reset.out_crc8", crc8, 32'd0);
    checkOutput("reset.out_len8", {16'd0, len8}, 32'd0);
    checkOutput("reset.fcs_ok8", {31'd0, ok8}, 32'd0);
    checkOutput("reset.busy8", {31'd0, busy8}, 32'd0);
    checkOutput("reset.out_valid32", {31'd0, ov32}, 32'd0);
    checkOutput("reset.out_crc32", crc32, 32'd0);
    rst = 1'b1;
    idle_cycles(1);

    $display("[TB] byte-wide generate of 123456789");
    q8.push_back('{32'hCBF43926, 1'b0, 16'd9});
    applyStimulus(1'b0, 32'h31, 4'b0001, 1'b0, 1'b0);
    checkOutput("busy_in_frame", {31'd0, busy8}, 32'd1);
    send_bytes8(str9[1:8], 1'b0, 1'b1);
    checkOutput("latency.out_valid", {31'd0, ov8}, 32'd1);
    idle_cycles(2);

    $display("[TB] 32-bit generate, partial last keep and single byte");
    q32.push_back('{32'hCBF43926, 1'b0, 16'd9});
    applyStimulus(1'b1, 32'h34333231, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h38373635, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00000039, 4'b0001, 1'b1, 1'b0);
    q32.push_back('{32'hD202EF8D, 1'b0, 16'd1});
    applyStimulus(1'b1, 32'h00000000, 4'b0001, 1'b1, 1'b0);
    idle_cycles(2);

    $display("[TB] 60-byte frame, generate then residue check");
    for (int i = 0; i < 60; i++) pay.push_back(8'(i * 7 + 3));
    fcs = ref_crc(pay);
    q8.push_back('{fcs, 1'b0, 16'd60});
    send_bytes8(pay, 1'b0, 1'b1);
    frm = pay;
    for (int j = 0; j < 4; j++) frm.push_back(fcs[8*j +: 8]);
    q8.push_back('{32'h2144DF1C, 1'b1, 16'd64});
    send_bytes8(frm, 1'b1, 1'b1);
    q32.push_back('{32'h2144DF1C, 1'b1, 16'd64});
    send_words32(frm, 1'b1);
    frm[10] = frm[10] ^ 8'h04;
    q8.push_back('{ref_crc(frm), 1'b0, 16'd64});
    send_bytes8(frm, 1'b1, 1'b1);
    idle_cycles(2);

    $display("[TB] backpressure on result");
    or8 = 1'b0;
    q8.push_back('{32'hCBF43926, 1'b0, 16'd9});
    send_bytes8(str9, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp.in_ready_low", {31'd0, ir8}, 32'd0);
      checkOutput("bp.out_valid_held", {31'd0, ov8}, 32'd1);
      checkOutput("bp.crc_stable", crc8, 32'hCBF43926);
      checkOutput("bp.len_stable", {16'd0, len8}, 32'd9);
    end
    @(posedge clk); #1;
    or8 = 1'b1;
    #1;
    checkOutput("bp.same_cycle_ready", {31'd0, ir8}, 32'd1);
    q8.push_back('{32'hCBF43926, 1'b0, 16'd9});
    send_bytes8(str9, 1'b0, 1'b1);
    idle_cycles(2);

    $display("[TB] reset mid-frame, then reset with result pending");
    send_bytes8(str9[0:2], 1'b0, 1'b0);
    rst = 1'b0;
    idle_cycles(1);
    rst = 1'b1;
    checkOutput("rst_mid.busy", {31'd0, busy8}, 32'd0);
    q8.push_back('{32'hCBF43926, 1'b0, 16'd9});
    send_bytes8(str9, 1'b0, 1'b1);
    idle_cycles(2);
    or8 = 1'b0;
    send_bytes8(str9, 1'b1, 1'b1);
    checkOutput("rst_pend.valid_before", {31'd0, ov8}, 32'd1);
    rst = 1'b0;
    idle_cycles(1);
    checkOutput("rst_pend.valid_dropped", {31'd0, ov8}, 32'd0);
    rst = 1'b1;
    or8 = 1'b1;
    idle_cycles(1);

    $display("[TB] empty last beat");
    q8.push_back('{32'hCBF43926, 1'b0, 16'd9});
    send_bytes8(str9, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hAA, 4'b0000, 1'b1, 1'b0);
    idle_cycles(3);

    checkOutput("scoreboard8.drained", q8.size(), 32'd0);
    checkOutput("scoreboard32.drained", q32.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
